serial_adder_32bit: RTL and testbench

Multi-cycle bit-serial two's-complement adder. It accepts two WIDTH-bit operands through a valid/ready handshake and adds them LSB-first, BITS_PER_CYCLE bits per clock, with a registered ripple carry. It presents the sum through a second valid/ready handshake. It is the addition-side companion to the combinational 32-bit subtractor in the ALU, for area-constrained datapaths that can tolerate multi-cycle latency.

---
 rtl/alu_pkg.sv | 13 +
 rtl/serial_add_chunk.sv | 36 +++
 rtl/serial_adder_32bit.sv | 137 +++++++++++++
 tb/tb_serial_adder_32bit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants and the serial adder state enum.
// Holds no logic; imported by the serial adder files.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_chunk.sv
// serial_add_chunk: combinational W-bit ripple adder slice.
// Ports: a_i/b_i chunk operands, ci_i carry in, s_o chunk sum,
// co_o carry out, msb_o sum MSB (only with SERIAL_ADDER_FLAGS_EN).
module serial_add_chunk
  import alu_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
`ifdef SERIAL_ADDER_FLAGS_EN
  ,
  output logic         msb_o
`endif
);

  logic c;

  always_comb begin
    s_o = '0;
    c   = ci_i;
    for (int i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

`ifdef SERIAL_ADDER_FLAGS_EN
  assign msb_o = s_o[W-1];
`endif

endmodule

// File: rtl/serial_adder_32bit.sv
// serial_adder_32bit: bit-serial adder, BITS_PER_CYCLE bits per clock.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready + a, b;
// out_valid/out_ready + y; cout, ovf with SERIAL_ADDER_FLAGS_EN.
module serial_adder_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH          = ALU_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef SERIAL_ADDER_FLAGS_EN
  ,
  output logic             cout,
  output logic             ovf
`endif
);

  localparam int BPC    = BITS_PER_CYCLE;
  localparam int NCHUNK = WIDTH / BPC;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % BPC != 0) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must divide WIDTH");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [BPC-1:0]       c_sum;
  logic                 c_co;
  logic [WIDTH+BPC-1:0] y_cat;
  logic [WIDTH-1:0]     y_d;

`ifdef SERIAL_ADDER_FLAGS_EN
  logic c_msb;
  logic cout_q;
  logic ovf_q;
`endif

  serial_add_chunk #(.W(BPC)) u_chunk (
    .a_i  (a_q[BPC-1:0]),
    .b_i  (b_q[BPC-1:0]),
    .ci_i (carry_q),
    .s_o  (c_sum),
    .co_o (c_co)
`ifdef SERIAL_ADDER_FLAGS_EN
    ,
    .msb_o(c_msb)
`endif
  );

  // New chunk enters at the top; after NCHUNK shifts chunk 0 is at the LSBs.
  assign y_cat = {c_sum, y_q};
  assign y_d   = y_cat[WIDTH+BPC-1:BPC];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          a_q     <= a_q >> BPC;
          b_q     <= b_q >> BPC;
          carry_q <= c_co;
          y_q     <= y_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NCHUNK - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SERIAL_ADDER_FLAGS_EN
            cout_q <= c_co;
            // Top chunk still holds the operand sign bits here.
            ovf_q  <= (a_q[BPC-1] == b_q[BPC-1])
                   && (c_msb != a_q[BPC-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
`ifdef SERIAL_ADDER_FLAGS_EN
  assign cout = cout_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_32bit.sv
// tb_serial_adder_32bit: randomized self-checking bench for the
// serial adder, default build and a BITS_PER_CYCLE=4 instance.
module tb_serial_adder_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] a4, b4, y4;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic        cout, ovf, cout4, ovf4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_32bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
`ifdef SERIAL_ADDER_FLAGS_EN
    ,
    .cout     (cout),
    .ovf      (ovf)
`endif
  );

  serial_adder_32bit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .a        (a4),
    .b        (b4),
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .y        (y4)
`ifdef SERIAL_ADDER_FLAGS_EN
    ,
    .cout     (cout4),
    .ovf      (ovf4)
`endif
  );

  // Reference: {ovf, cout, sum[31:0]} from plain integer addition.
  function automatic logic [33:0] ref_add(input logic [31:0] x,
                                          input logic [31:0] z);
    logic [32:0] s;
    logic        v;
    s = {1'b0, x} + {1'b0, z};
    v = (x[31] == z[31]) && (s[31] != x[31]);
    return {v, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] x, input logic [31:0] z);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    a = x;
    b = z;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; waits for out_valid.
  task automatic check_result(input string nm, input logic [31:0] x,
                              input logic [31:0] z, input int lat);
    int n;
    logic [33:0] e;
    e = ref_add(x, z);
    n = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy in_ready=%b required=0", nm, in_ready);
    end
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d required=%0d", nm, n, lat);
    end
    checks++;
    if (y !== e[31:0]) begin
      errors++;
      $display("FAIL %s_y got=%h required=%h", nm, y, e[31:0]);
    end
`ifdef SERIAL_ADDER_FLAGS_EN
    checks++;
    if (cout !== e[32] || ovf !== e[33]) begin
      errors++;
      $display("FAIL %s_flags got=%b%b required=%b%b",
               nm, cout, ovf, e[32], e[33]);
    end
`endif
  endtask

  // Handshake edge with out_ready=1; block must be idle and ready.
  task automatic check_release(input string nm);
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release out_valid=%b in_ready=%b required=0 1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || y !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals in_ready=%b out_valid=%b y=%h required=0 0 0",
               in_ready, out_valid, y);
    end
`ifdef SERIAL_ADDER_FLAGS_EN
    checks++;
    if (cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b required=00", cout, ovf);
    end
`endif
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    accept(32'd5, 32'd3);
    check_result("add_5_3", 32'd5, 32'd3, 32);
    check_release("add_5_3");
    accept(32'hFFFFFFFF, 32'h1);
    check_result("carry", 32'hFFFFFFFF, 32'h1, 32);
    check_release("carry");
    accept(32'h7FFFFFFF, 32'h1);
    check_result("ovf", 32'h7FFFFFFF, 32'h1, 32);
    check_release("ovf");
  endtask

  task automatic test_random();
    logic [31:0] x, z;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      z = $urandom;
      accept(x, z);
      check_result("random", x, z, 32);
      check_release("random");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x, z, c, d;
    logic [33:0] e;
    x = $urandom; z = $urandom;
    c = $urandom; d = $urandom;
    e = ref_add(x, z);
    out_ready = 1'b0;
    accept(x, z);
    check_result("bp", x, z, 32);
    a = c;
    b = d;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || y !== e[31:0] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold out_valid=%b y=%h in_ready=%b required=1 %h 0",
                 out_valid, y, in_ready, e[31:0]);
      end
    end
    out_ready = 1'b1;
    check_release("bp");
    step();
    in_valid = 1'b0;
    check_result("bp_next", c, d, 32);
    check_release("bp_next");
  endtask

  task automatic test_reset_abort();
    int seen;
    out_ready = 1'b1;
    accept($urandom, $urandom);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || y !== 32'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset out_valid=%b y=%h in_ready=%b required=0 0 0",
               out_valid, y, in_ready);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_result valid_cycles=%0d required=0", seen);
    end
    accept(32'd100, 32'd200);
    check_result("after_abort", 32'd100, 32'd200, 32);
    check_release("after_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, z1, x2, z2;
    x1 = $urandom; z1 = $urandom;
    x2 = $urandom; z2 = $urandom;
    out_ready = 1'b1;
    accept(x1, z1);
    a = x2;
    b = z2;
    in_valid = 1'b1;
    check_result("b2b_first", x1, z1, 32);
    check_release("b2b_first");
    step();
    in_valid = 1'b0;
    check_result("b2b_second", x2, z2, 32);
    check_release("b2b_second");
  endtask

  task automatic test_bpc4();
    logic [31:0] xs[4];
    logic [31:0] zs[4];
    logic [33:0] e;
    int n;
    xs[0] = 32'h12345678; zs[0] = 32'h11111111;
    for (int i = 1; i < 4; i++) begin
      xs[i] = $urandom;
      zs[i] = $urandom;
    end
    out_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = ref_add(xs[i], zs[i]);
      n = 0;
      while (in_ready4 !== 1'b1 && n < 100) begin
        step();
        n++;
      end
      a4 = xs[i];
      b4 = zs[i];
      in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      n = 0;
      while (out_valid4 !== 1'b1 && n < 100) begin
        step();
        n++;
      end
      checks++;
      if (n !== 8) begin
        errors++;
        $display("FAIL bpc4_latency got=%0d required=8", n);
      end
      checks++;
      if (y4 !== e[31:0]) begin
        errors++;
        $display("FAIL bpc4_y got=%h required=%h", y4, e[31:0]);
      end
`ifdef SERIAL_ADDER_FLAGS_EN
      checks++;
      if (cout4 !== e[32] || ovf4 !== e[33]) begin
        errors++;
        $display("FAIL bpc4_flags got=%b%b required=%b%b",
                 cout4, ovf4, e[32], e[33]);
      end
`endif
      step();
      checks++;
      if (out_valid4 !== 1'b0) begin
        errors++;
        $display("FAIL bpc4_release out_valid=%b required=0", out_valid4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_bpc4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
